// File: rtl/result_pkg.sv
// result_pkg: shared widths and FSM state encoding for the result drain path
package result_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 2;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
endpackage

// File: rtl/result_buffer.sv
// result_buffer: circular register array with push/pop strobes, occupancy count and sticky overflow
module result_buffer
  import result_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic full, do_push;
  assign full = count == (ADDR_W+1)'(DEPTH);
  // a full buffer still takes a word when a pop frees a slot in the same cycle
  assign do_push = push && (!full || pop);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + ADDR_W'(do_push);
      rd_ptr   <= rd_ptr + ADDR_W'(pop);
      count    <= count + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(pop);
      overflow <= overflow | (push & full & ~pop);
    end
  end
  always_ff @(posedge clk) begin
    if (Reset && do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/result_reader.sv
// result_reader: captures datapath results and streams them out over valid/ready on start
module result_reader
  import result_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  state_t state, state_nx;
  logic [DATA_W-1:0] rd_data;
  logic hs;
  assign out_valid = state == DRAIN;
  assign busy      = state == DRAIN;
  assign done      = state == DONE;
  assign hs        = out_valid && out_ready;
  assign out_data  = out_valid ? rd_data : '0;
  result_buffer u_buf (
    .clk(clk), .Reset(Reset), .push(wr_en), .pop(hs), .wr_data(wr_data),
    .rd_data(rd_data), .count(count), .overflow(overflow)
  );
  always_ff @(posedge clk) begin
    if (!Reset) state <= IDLE;
    else state <= state_nx;
  end
  // with count at 1 the buffer is never full, so any write lands and keeps the drain going
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = count != '0 ? DRAIN : DONE;
    if (state == DRAIN && hs && count == (ADDR_W+1)'(1) && !wr_en) state_nx = DONE;
    if (state == DONE) state_nx = IDLE;
  end
endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: scoreboard bench, directed vectors against a queue of expected beats
module tb_result_reader;
  import result_pkg::*;
  logic clk = 0, reset_n = 0, wr_en = 0, start = 0, out_ready = 0;
  logic [DATA_W-1:0] wr_data = '0;
  logic out_valid, busy, done, overflow;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0] count;
  int vectors = 0, miscompares = 0, beats = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic stalled = 0;
  logic [DATA_W-1:0] held = '0;

  result_reader dut (
    .clk(clk), .Reset(reset_n), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .done(done), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && stalled) begin
        vectors++;
        if (out_data !== held) begin
          miscompares++;
          $display("FAIL stall_hold: out_data=%0h required %0h", out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        beats++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: out_data=%0h required no beat", out_data);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            miscompares++;
            $display("FAIL beat: out_data=%0h required %0h", out_data, e);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held = out_data;
    end else stalled = 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic write(input logic [DATA_W-1:0] v);
    wr_en = 1;
    wr_data = v;
    step();
    wr_en = 0;
  endtask

  task automatic kick();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic wait_done(input bit toggle);
    for (int i = 0; i < 40 && !done; i++) begin
      if (toggle) out_ready = (i % 3 == 0);
      step();
    end
    chk("done_seen", done, 1);
    out_ready = 1;
  endtask

  task automatic reset_dut();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
  endtask

  task automatic fill4();
    write(8'h11); write(8'h22); write(8'h33); write(8'h44);
  endtask

  initial begin
    reset_dut();
    reset_n = 0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1;
    // straight drain with ready held high
    fill4();
    chk("fill_count", count, 4);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1;
    kick();
    chk("drain_valid", out_valid, 1);
    chk("drain_busy", busy, 1);
    chk("first_word", out_data, 8'h11);
    step(); step(); step();
    chk("count_after3", count, 1);
    step();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", out_valid, 0);
    chk("drain_count", count, 0);
    step();
    chk("done_drop", done, 0);
    chk("q_empty1", exp_q.size(), 0);
    // stalling downstream
    fill4();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    beats = 0;
    kick();
    wait_done(1);
    chk("stall_beats", beats, 4);
    step();
    chk("q_empty2", exp_q.size(), 0);
    // overflow
    out_ready = 0;
    fill4();
    write(8'h55);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1;
    kick();
    wait_done(0);
    chk("ovf_sticky", overflow, 1);
    step();
    chk("q_empty3", exp_q.size(), 0);
    reset_dut();
    chk("ovf_clear", overflow, 0);
    // empty start
    kick();
    chk("empty_valid", out_valid, 0);
    chk("empty_done", done, 1);
    step();
    chk("empty_done_drop", done, 0);
    // write coinciding with the last handshake
    write(8'h61); write(8'h62);
    exp_q = '{8'h61, 8'h62, 8'h77};
    kick();
    step();
    chk("sim_count1", count, 1);
    wr_en = 1;
    wr_data = 8'h77;
    step();
    wr_en = 0;
    chk("sim_count_hold", count, 1);
    chk("sim_still_valid", out_valid, 1);
    step();
    chk("sim_done", done, 1);
    chk("sim_count0", count, 0);
    step();
    chk("q_empty4", exp_q.size(), 0);
    // reset in the middle of a drain
    write(8'ha1); write(8'ha2); write(8'ha3); write(8'ha4);
    exp_q = '{8'ha1, 8'ha2};
    kick();
    step(); step();
    reset_n = 0;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_count", count, 0);
    reset_n = 1;
    chk("q_empty5", exp_q.size(), 0);
    write(8'hb1); write(8'hb2);
    exp_q = '{8'hb1, 8'hb2};
    kick();
    wait_done(0);
    step();
    chk("q_empty6", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
